foo_channel_arbiter: RTL and testbench
======================================

// Module: foo_channel_arbiter
// PURPOSE
//  Round-robin arbiter that shares one foo_t (4-bit packed enum) channel among N requesters.
//  Sits in front of the dut pass-through port.
//  Each requester presents a valid/ready beat; the winner's value is registered onto the shared output.
//  The source index travels with the beat.
// PARAMETERS
//  N_REQ     4   number of requesters (2..16)
//  IDX_W     $clog2(N_REQ)  width of source index (derived localparam, not overridable)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous reset, active-high
//  req_valid  in   N_REQ        per-requester beat valid
//  req_data   in   [N_REQ][4]   packed array of foo_pkg::foo_t, one per requester
//  req_last   in   N_REQ        last beat of burst (used only with FOO_ARB_LOCK_EN)
//  req_ready  out  N_REQ        one-hot accept; at most one bit high per cycle
//  out_valid  out  1            shared channel beat valid
//  out_data   out  4            foo_pkg::foo_t granted value
//  out_src    out  IDX_W        index of requester that produced out_data
//  out_ready  in   1            downstream accept
// BEHAVIOUR
//  Reset (async assert, sync deassert at source): out_valid=0, out_data=FOO, out_src=0, ptr=N_REQ-1, state=EMPTY.
//  req_ready is combinational: all zeros while in reset.
//  Output stage is a single register with state EMPTY/FULL.
//  - load = (state==EMPTY || out_ready) && |req_valid_eligible
//  - Winner = first eligible i scanning ptr+1, ptr+2 ... wrapping mod N_REQ.
//  - req_ready[winner]=load; no other bit ever high.
//  - On load: out_data<=req_data[winner], out_src<=winner, ptr<=winner, state<=FULL.
//  - FULL && out_ready && !load -> EMPTY (out_valid<=0, out_data/out_src hold).
//  - FULL && !out_ready: all req_ready=0, outputs stable (no drop, no overwrite).
//  Latency: accepted beat appears on out_valid the next cycle.
//  Throughput: 1 beat/cycle when out_ready is held high (simultaneous drain + load).
//  Fairness: a continuously valid requester is served within N_REQ accepted beats.
//  Single requester: served every cycle; ptr lands on it.
//  Requester deasserting valid before ready: no effect, no grant lost.
//  Reset mid-beat: in-flight output beat discarded, ptr returns to N_REQ-1 (first grant goes to req 0).
// CONFIGURATION
//  FOO_ARB_LOCK_EN defined:
//  - Adds lock flag and lock_idx.
//  - Accepting a beat with req_last[winner]=0 sets lock; only lock_idx is eligible until a beat with req_last=1 is accepted.
//  - Lock clears on that accept; ptr advances only on the last beat.
//  - Reset clears lock.
//  FOO_ARB_LOCK_EN undefined:
//  - req_last ignored (port kept, unconnected internally).
//  - Arbitration re-runs every beat.
// STRUCTURE
//  foo_pkg: typedef enum logic [3:0] {FOO} foo_t; typedef enum logic {EMPTY, FULL} arb_state_t.
//  Sub-module foo_rr_pick: combinational, N_REQ/eligible/ptr -> winner index + any flag; rotate-and-priority-encode.
//  Top holds state register, output register, ptr, lock logic.
// TESTING
//  (N_REQ=4 throughout)
//  1. Reset, req_valid=4'b1111, out_ready=1:
//     - grants 0,1,2,3,0 on consecutive cycles
//     - out_src follows one cycle later
//  2. req_valid=4'b0100, data=FOO, out_ready=0:
//     - one accept, out_valid=1 out_src=2
//     - req_ready=0 thereafter until out_ready=1
//  3. FULL, out_ready=1, req_valid=0:
//     - out_valid drops next cycle
//     - ptr stays 2; next req_valid=4'b0101 grants 0 (scan 3,0)
//  4. Assert rst while out_valid=1:
//     - out_valid=0 immediately (async)
//     - first grant after release goes to req 0
//  5. One-hot check:
//     - random req_valid/out_ready for 10k cycles
//     - $onehot0(req_ready) every cycle; every accepted value reappears exactly once on out_data with matching out_src
//  6. FOO_ARB_LOCK_EN defined:
//     - req1 burst of 3 (last on 3rd), req_valid=4'b0011: grants 1,1,1 then 0
//     - without macro: grants 0,1,0,1

Source files
------------

// File: rtl/foo_pkg.sv
// Shared types for the foo channel arbiter: channel value enum and output-stage state.
package foo_pkg;
    typedef enum logic [3:0] {FOO} foo_t;
    typedef enum logic {EMPTY, FULL} arb_state_t;
endpackage

// File: rtl/foo_rr_pick.sv
// Combinational round-robin pick: first eligible requester after ptr, wrapping mod N_REQ.
module foo_rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);
    always_comb begin
        int j;
        winner = '0;
        any    = 1'b0;
        j      = 0;
        // Scan ptr+1 .. ptr+N_REQ so the last winner has the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && eligible[j]) begin
                any    = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/foo_channel_arbiter.sv
// Round-robin arbiter sharing one registered foo_t channel among N_REQ requesters.
// Optional burst locking is enabled with the FOO_ARB_LOCK_EN macro.
module foo_channel_arbiter
    import foo_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][3:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [3:0]            out_data,
    output logic [IDX_W-1:0]      out_src,
    input  logic                  out_ready
);
    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [N_REQ-1:0] eligible;
    logic             any;
    logic             load;

`ifdef FOO_ARB_LOCK_EN
    logic             lock;
    logic [IDX_W-1:0] lock_idx;
    // While a burst is open only its owner may be granted.
    assign eligible = lock ? (req_valid & (N_REQ'(1) << lock_idx)) : req_valid;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    foo_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .any      (any)
    );

    // Gated by rst so no requester sees an accept while the block is held in reset.
    assign load      = !rst && (state == EMPTY || out_ready) && any;
    assign req_ready = load ? (N_REQ'(1) << winner) : '0;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= FOO;
            out_src  <= '0;
            ptr      <= IDX_W'(N_REQ - 1);
`ifdef FOO_ARB_LOCK_EN
            lock     <= 1'b0;
            lock_idx <= '0;
`endif
        end else if (load) begin
            state    <= FULL;
            out_data <= req_data[winner];
            out_src  <= winner;
`ifdef FOO_ARB_LOCK_EN
            if (req_last[winner]) begin
                lock <= 1'b0;
                ptr  <= winner;
            end else begin
                lock     <= 1'b1;
                lock_idx <= winner;
            end
`else
            ptr      <= winner;
`endif
        end else if (state == FULL && out_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_foo_channel_arbiter.sv
// Directed and randomized checks for foo_channel_arbiter (N_REQ=4); FOO_ARB_LOCK_EN selects the burst test.
module tb_foo_channel_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0][3:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [3:0]     out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    foo_channel_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
    );

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_last = 4'b1111;
        req_data = {4'h0, 4'h0, 4'h0, 4'h0};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h src=%0d ready=%b, want 0 0 0 0000",
                     out_valid, out_data, out_src, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        req_valid = 4'b1111;
        req_data  = {4'hd, 4'hc, 4'hb, 4'ha};
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ready=%b want %b", c, req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== 4'(4'ha + (c % 4))) begin
                errors++;
                $display("FAIL rr_out[%0d]: valid=%b src=%0d data=%h want 1 %0d %h",
                         c, out_valid, out_src, out_data, c % 4, 4'ha + (c % 4));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        // ptr sits at 0; drain first so the single request finds the stage EMPTY.
        req_valid = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = {4'h0, 4'h0, 4'h0, 4'h0};
        out_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_accept: ready=%b want 0100", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 4'h0) begin
            errors++;
            $display("FAIL stall_out: valid=%b src=%0d data=%h want 1 2 0", out_valid, out_src, out_data);
        end
        @(negedge clk);
        req_data = {4'h0, 4'h7, 4'h0, 4'h0};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 4'h0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ready=%b valid=%b src=%0d data=%h want 0000 1 2 0",
                         c, req_ready, out_valid, out_src, out_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_src !== 2'd2) begin
            errors++;
            $display("FAIL drain: valid=%b src=%0d want 0 2", out_valid, out_src);
        end
        @(negedge clk);
        req_valid = 4'b0101;
        req_data  = {4'h0, 4'h5, 4'h0, 4'h9};
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant: ready=%b want 0001", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'h9) begin
            errors++;
            $display("FAIL wrap_out: valid=%b src=%0d data=%h want 1 0 9", out_valid, out_src, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        // Move ptr away from N-1 first so the post-reset grant proves it was restored.
        req_valid = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0000;
        out_ready = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: valid=%b src=%0d ready=%b want 0 0 0000", out_valid, out_src, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: ready=%b want 0001", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] q[$];
        logic [5:0] exp;
        logic       ovld, ordy;
        logic [3:0] odat;
        logic [1:0] osrc, widx;
        do_reset();
        for (int c = 0; c < 10002; c++) begin
            if (c < 10000) begin
                req_valid = 4'($urandom_range(0, 15));
                req_last  = 4'($urandom_range(0, 15));
                out_ready = 1'($urandom_range(0, 1));
                for (int i = 0; i < N; i++) req_data[i] = 4'($urandom_range(0, 15));
            end else begin
                req_valid = 4'b0000;
                out_ready = 1'b1;
            end
            #1;
            ovld = out_valid; ordy = out_ready; odat = out_data; osrc = out_src;
            if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 4'b0000) begin
                checks++; errors++;
                $display("FAIL onehot[%0d]: ready=%b valid=%b", c, req_ready, req_valid);
            end
            if (ovld && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra[%0d]: data=%h src=%0d with nothing expected", c, odat, osrc);
                end else begin
                    exp = q.pop_front();
                    if ({odat, osrc} !== exp) begin
                        errors++;
                        $display("FAIL sb_beat[%0d]: data=%h src=%0d want %h %0d",
                                 c, odat, osrc, exp[5:2], exp[1:0]);
                    end
                end
            end
            if (req_ready != 4'b0000) begin
                widx = 2'd0;
                for (int i = 0; i < N; i++) if (req_ready[i]) widx = 2'(i);
                q.push_back({req_data[widx], widx});
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_drain: pending=%0d valid=%b want 0 0", q.size(), out_valid);
        end
    endtask

    task automatic test_lock();
        logic [1:0] exp_src[4];
        do_reset();
        req_last  = 4'b1111;
        out_ready = 1'b1;
`ifdef FOO_ARB_LOCK_EN
        // One beat from req0 parks ptr on 0 so the burst owner is req1.
        req_valid = 4'b0001;
        @(negedge clk);
        exp_src = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
        exp_src = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        req_valid = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            req_last = {2'b11, (c == 2 || c == 3), 1'b1};
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_src !== exp_src[c]) begin
                errors++;
                $display("FAIL lock_seq[%0d]: valid=%b src=%0d want 1 %0d", c, out_valid, out_src, exp_src[c]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_drain();
        test_async_reset();
        test_random();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
